// File: rtl/pakout_ser_pkg.sv
// Shared definitions for the packet serializer: output FSM states and the
// derived message/packet sizes.
package pakout_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  localparam int PSZ_DEF    = 4;
  localparam int ASZ_DEF    = 6;
  localparam int DSZ_DEF    = 4;
  localparam int RSZ_DEF    = 4;
  localparam int FDEPTH_DEF = 2;

  // MSZ: {src,dst,dat,red}
  function automatic int msg_size(input int asz, input int dsz, input int rsz);
    return 2 * asz + dsz + rsz;
  endfunction

  // TOT_PKS: ceil(MSZ/PSZ)
  function automatic int num_packets(input int msz, input int psz);
    return (msz + psz - 1) / psz;
  endfunction

endpackage

// File: rtl/pakout_ser_msg_fifo.sv
// Message buffer between the input handshake and the packet FSM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module msg_fifo
  import pakout_ser_pkg::*;
#(
  parameter int FDEPTH = FDEPTH_DEF,
  parameter int WIDTH  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FDEPTH);

  logic [WIDTH-1:0] mem [FDEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/pakout_ser.sv
// Message-to-packet serializer: four-phase message input, buffered in a FIFO,
// emitted MSB-first as PSZ-bit packets over a four-phase output handshake.
module pakout_ser
  import pakout_ser_pkg::*;
#(
  parameter int PSZ    = PSZ_DEF,
  parameter int ASZ    = ASZ_DEF,
  parameter int DSZ    = DSZ_DEF,
  parameter int RSZ    = RSZ_DEF,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [PSZ-1:0] o0_pak,
  output logic           o0_req,
  input  logic           o0_ack
);

  localparam int MSZ     = msg_size(ASZ, DSZ, RSZ);
  localparam int TOT_PKS = num_packets(MSZ, PSZ);
  localparam int PADW    = TOT_PKS * PSZ;
  localparam int CNT_W   = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;

  logic             ack_s1;
  logic             ack_s;
  logic [MSZ-1:0]   fifo_din;
  logic [MSZ-1:0]   fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [PADW-1:0]  padded;
  logic [PADW-1:0]  shreg;
  logic [CNT_W-1:0] cnt;
  logic             last;
  state_t           state;
  state_t           state_nx;

  assign fifo_din = {i0_src, i0_dst, i0_dat, i0_red};
  assign push     = i0_req && !i0_ack && !fifo_full;
  assign padded   = PADW'(fifo_dout) << (PADW - MSZ);
  assign last     = (cnt == CNT_W'(TOT_PKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
      i0_ack <= 1'b0;
    end else begin
      ack_s1 <= o0_ack;
      ack_s  <= ack_s1;
      if (push)         i0_ack <= 1'b1;
      else if (!i0_req) i0_ack <= 1'b0;
    end
  end

  msg_fifo #(
    .FDEPTH (FDEPTH),
    .WIDTH  (MSZ)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // The head entry stays in the FIFO until its last packet is acknowledged.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:    if (!fifo_empty) state_nx = LOAD;
      LOAD:    state_nx = REQ_HI;
      REQ_HI:  if (ack_s) state_nx = REQ_LO;
      REQ_LO: begin
        if (!ack_s) begin
          if (last) begin
            pop      = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = LOAD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // o0_pak is loaded on entry to LOAD, so it holds through REQ_HI and REQ_LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      shreg  <= '0;
      o0_pak <= '0;
      o0_req <= 1'b0;
    end else begin
      o0_req <= (state_nx == REQ_HI);
      if (state == IDLE && state_nx == LOAD) begin
        cnt    <= '0;
        o0_pak <= padded[PADW-1 -: PSZ];
        shreg  <= padded << PSZ;
      end else if (state == REQ_LO && state_nx == LOAD) begin
        cnt    <= cnt + CNT_W'(1);
        o0_pak <= shreg[PADW-1 -: PSZ];
        shreg  <= shreg << PSZ;
      end
    end
  end

endmodule

// File: tb/tb_pakout_ser.sv
// Directed bench for pakout_ser: default build plus a PSZ=3 build, with a
// configurable-latency packet peer on the output handshake.
module tb_pakout_ser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] i0_src = '0;
  logic [5:0] i0_dst = '0;
  logic [3:0] i0_dat = '0;
  logic [3:0] i0_red = '0;
  logic       i0_req = 1'b0;
  logic       i0_ack;
  logic [3:0] o0_pak;
  logic       o0_req;
  logic       o0_ack = 1'b0;

  logic       i0_req_b = 1'b0;
  logic       i0_ack_b;
  logic [2:0] o0_pak_b;
  logic       o0_req_b;
  logic       o0_ack_b = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [3:0] cap[$];
  logic [2:0] cap_b[$];
  int         rises[$];
  int         peer_delay = 0;
  logic       peer_en = 1'b0;
  int         pcnt = 0;
  int         cyc = 0;
  logic       prev_req = 1'b0;
  logic [3:0] held = '0;
  int         stab_err = 0;

  always #5 clk = ~clk;

  pakout_ser dut (
    .clk    (clk),
    .reset  (reset),
    .i0_src (i0_src),
    .i0_dst (i0_dst),
    .i0_dat (i0_dat),
    .i0_red (i0_red),
    .i0_req (i0_req),
    .i0_ack (i0_ack),
    .o0_pak (o0_pak),
    .o0_req (o0_req),
    .o0_ack (o0_ack)
  );

  pakout_ser #(.PSZ(3)) dut3 (
    .clk    (clk),
    .reset  (reset),
    .i0_src (i0_src),
    .i0_dst (i0_dst),
    .i0_dat (i0_dat),
    .i0_red (i0_red),
    .i0_req (i0_req_b),
    .i0_ack (i0_ack_b),
    .o0_pak (o0_pak_b),
    .o0_req (o0_req_b),
    .o0_ack (o0_ack_b)
  );

  always @(posedge clk) cyc = cyc + 1;

  // Packet peer: mirrors o0_req onto o0_ack after peer_delay extra negedges.
  always @(negedge clk) begin
    if (!peer_en) begin
      o0_ack = 1'b0;
      pcnt = 0;
    end else if (o0_ack == o0_req) begin
      pcnt = 0;
    end else if (pcnt >= peer_delay) begin
      if (o0_req) cap.push_back(o0_pak);
      o0_ack = o0_req;
      pcnt = 0;
    end else begin
      pcnt = pcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (o0_req_b && !o0_ack_b) cap_b.push_back(o0_pak_b);
    o0_ack_b = o0_req_b;
  end

  always @(negedge clk) begin
    if (o0_req && !prev_req) begin
      held = o0_pak;
      rises.push_back(cyc);
    end else if (o0_req && o0_pak !== held) begin
      stab_err = stab_err + 1;
    end
    prev_req = o0_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int budget);
    int k = 0;
    while (i0_ack !== lvl && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (i0_ack !== lvl) begin
      failures++;
      $display("FAIL wait_i0_ack: i0_ack=%b, required %b within %0d cycles", i0_ack, lvl, budget);
    end
  endtask

  task automatic wait_cap(input int n, input int budget);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (cap.size() < n) begin
      failures++;
      $display("FAIL wait_packets: got %0d packets, required %0d", cap.size(), n);
    end
  endtask

  task automatic send_msg(input logic [5:0] s, input logic [5:0] d,
                          input logic [3:0] t, input logic [3:0] r);
    i0_src = s;
    i0_dst = d;
    i0_dat = t;
    i0_red = r;
    i0_req = 1'b1;
    wait_ack(1'b1, 200);
    i0_req = 1'b0;
    wait_ack(1'b0, 200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (i0_ack !== 1'b0) begin failures++; $display("FAIL reset_i0_ack: got %b, required 0", i0_ack); end
    checks++;
    if (o0_req !== 1'b0) begin failures++; $display("FAIL reset_o0_req: got %b, required 0", o0_req); end
    checks++;
    if (o0_pak !== 4'h0) begin failures++; $display("FAIL reset_o0_pak: got %h, required 0", o0_pak); end
    checks++;
    if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_fifo_empty: got %b, required 1", dut.fifo_empty); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [3:0] exp_p [5] = '{4'h0, 4'hC, 4'h1, 4'h5, 4'hF};
    int b = cap.size();
    peer_delay = 0;
    peer_en = 1'b1;
    send_msg(6'd3, 6'd1, 4'd5, 4'hF);
    wait_cap(b + 5, 300);
    repeat (12) step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[b+i] !== exp_p[i]) begin
        failures++;
        $display("FAIL single_pkt%0d: got %h, required %h", i, cap[b+i], exp_p[i]);
      end
    end
    checks++;
    if (cap.size() !== b + 5) begin failures++; $display("FAIL single_count: got %0d packets, required %0d", cap.size() - b, 5); end
    checks++;
    if (o0_req !== 1'b0) begin failures++; $display("FAIL single_idle_req: got %b, required 0", o0_req); end
    checks++;
    if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL single_fifo_empty: got %b, required 1", dut.fifo_empty); end
  endtask

  task automatic test_fifo_full();
    logic [3:0] exp_p [15] = '{4'h0, 4'hC, 4'h1, 4'h5, 4'hF,
                               4'hA, 4'h9, 4'h5, 4'h9, 4'h3,
                               4'hF, 4'hC, 4'h0, 4'h0, 4'h1};
    logic early = 1'b0;
    int b = cap.size();
    peer_en = 1'b0;
    peer_delay = 0;
    repeat (3) step();
    send_msg(6'd3, 6'd1, 4'd5, 4'hF);
    send_msg(6'h2A, 6'h15, 4'h9, 4'h3);
    checks++;
    if (dut.fifo_full !== 1'b1) begin failures++; $display("FAIL full_flag: got %b, required 1", dut.fifo_full); end
    i0_src = 6'h3F;
    i0_dst = 6'h00;
    i0_dat = 4'h0;
    i0_red = 4'h1;
    i0_req = 1'b1;
    repeat (30) begin
      step();
      if (i0_ack !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin failures++; $display("FAIL full_holdoff: i0_ack rose=%b, required 0", early); end
    checks++;
    if (o0_req !== 1'b1) begin failures++; $display("FAIL full_stall_req: got %b, required 1", o0_req); end
    checks++;
    if (cap.size() !== b) begin failures++; $display("FAIL full_stall_count: got %0d packets, required 0", cap.size() - b); end
    peer_en = 1'b1;
    wait_ack(1'b1, 400);
    checks++;
    if (cap.size() !== b + 5) begin failures++; $display("FAIL full_release_point: got %0d packets, required 5", cap.size() - b); end
    i0_req = 1'b0;
    wait_ack(1'b0, 50);
    wait_cap(b + 15, 1000);
    repeat (12) step();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (cap[b+i] !== exp_p[i]) begin
        failures++;
        $display("FAIL order_pkt%0d: got %h, required %h", i, cap[b+i], exp_p[i]);
      end
    end
  endtask

  task automatic test_slow_peer();
    logic [3:0] exp_p [5] = '{4'hF, 4'hC, 4'h0, 4'h0, 4'h1};
    int b = cap.size();
    int rb = rises.size();
    int se0 = stab_err;
    int minp = 1000000;
    peer_delay = 7;
    send_msg(6'h3F, 6'h00, 4'h0, 4'h1);
    wait_cap(b + 5, 2000);
    repeat (40) step();
    for (int i = rb + 1; i < rises.size(); i++)
      if (rises[i] - rises[i-1] < minp) minp = rises[i] - rises[i-1];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[b+i] !== exp_p[i]) begin
        failures++;
        $display("FAIL slow_pkt%0d: got %h, required %h", i, cap[b+i], exp_p[i]);
      end
    end
    checks++;
    if (stab_err !== se0) begin failures++; $display("FAIL slow_stability: o0_pak changed %0d times under o0_req, required 0", stab_err - se0); end
    checks++;
    if (minp < 18 || minp > 200) begin failures++; $display("FAIL slow_period: min period %0d cycles, required 18..200", minp); end
    peer_delay = 0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_p [5] = '{4'h0, 4'hC, 4'h1, 4'h5, 4'hF};
    int b = cap.size();
    int b2;
    peer_delay = 2;
    send_msg(6'h2A, 6'h15, 4'h9, 4'h3);
    send_msg(6'h3F, 6'h00, 4'h0, 4'h1);
    wait_cap(b + 3, 500);
    checks++;
    if (o0_req !== 1'b1) begin failures++; $display("FAIL midrst_pre_req: got %b, required 1", o0_req); end
    reset = 1'b1;
    peer_en = 1'b0;
    step();
    checks++;
    if (o0_req !== 1'b0) begin failures++; $display("FAIL midrst_o0_req: got %b, required 0", o0_req); end
    checks++;
    if (i0_ack !== 1'b0) begin failures++; $display("FAIL midrst_i0_ack: got %b, required 0", i0_ack); end
    checks++;
    if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL midrst_fifo_empty: got %b, required 1", dut.fifo_empty); end
    checks++;
    if (o0_pak !== 4'h0) begin failures++; $display("FAIL midrst_o0_pak: got %h, required 0", o0_pak); end
    reset = 1'b0;
    repeat (3) step();
    b2 = cap.size();
    peer_delay = 0;
    peer_en = 1'b1;
    repeat (10) step();
    checks++;
    if (o0_req !== 1'b0 || cap.size() !== b2) begin
      failures++;
      $display("FAIL midrst_discard: o0_req=%b new packets=%0d, required 0 and 0", o0_req, cap.size() - b2);
    end
    send_msg(6'd3, 6'd1, 4'd5, 4'hF);
    wait_cap(b2 + 5, 300);
    repeat (12) step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[b2+i] !== exp_p[i]) begin
        failures++;
        $display("FAIL midrst_pkt%0d: got %h, required %h", i, cap[b2+i], exp_p[i]);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [3:0] exp_p [5] = '{4'hA, 4'h9, 4'h5, 4'h9, 4'h3};
    int b = cap.size();
    int k = 0;
    peer_delay = 0;
    peer_en = 1'b1;
    send_msg(6'd3, 6'd1, 4'd5, 4'hF);
    wait_cap(b + 5, 300);
    while (o0_ack !== 1'b0 && k < 50) begin
      step();
      k++;
    end
    checks++;
    if (o0_ack !== 1'b0) begin failures++; $display("FAIL pushpop_ack_drop: o0_ack=%b, required 0", o0_ack); end
    // The pop lands on the third edge after the peer drops o0_ack.
    step();
    step();
    i0_src = 6'h2A;
    i0_dst = 6'h15;
    i0_dat = 4'h9;
    i0_red = 4'h3;
    i0_req = 1'b1;
    step();
    checks++;
    if (i0_ack !== 1'b1) begin failures++; $display("FAIL pushpop_i0_ack: got %b, required 1", i0_ack); end
    checks++;
    if (dut.fifo_empty !== 1'b0 || dut.fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_occupancy: empty=%b full=%b, required empty=0 full=0", dut.fifo_empty, dut.fifo_full);
    end
    checks++;
    if (o0_req !== 1'b0) begin failures++; $display("FAIL pushpop_idle: o0_req=%b, required 0", o0_req); end
    i0_req = 1'b0;
    wait_ack(1'b0, 50);
    wait_cap(b + 10, 400);
    repeat (12) step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap[b+5+i] !== exp_p[i]) begin
        failures++;
        $display("FAIL pushpop_pkt%0d: got %h, required %h", i, cap[b+5+i], exp_p[i]);
      end
    end
    checks++;
    if (dut.fifo_empty !== 1'b1) begin failures++; $display("FAIL pushpop_drained: fifo_empty=%b, required 1", dut.fifo_empty); end
  endtask

  task automatic test_psz3();
    logic [2:0] exp_p [7] = '{3'd0, 3'd3, 3'd0, 3'd1, 3'd2, 3'd7, 3'd6};
    int k = 0;
    i0_src = 6'd3;
    i0_dst = 6'd1;
    i0_dat = 4'd5;
    i0_red = 4'hF;
    i0_req_b = 1'b1;
    while (i0_ack_b !== 1'b1 && k < 100) begin step(); k++; end
    i0_req_b = 1'b0;
    k = 0;
    while (i0_ack_b !== 1'b0 && k < 100) begin step(); k++; end
    k = 0;
    while (cap_b.size() < 7 && k < 400) begin step(); k++; end
    repeat (12) step();
    checks++;
    if (cap_b.size() !== 7) begin failures++; $display("FAIL psz3_count: got %0d packets, required 7", cap_b.size()); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cap_b[i] !== exp_p[i]) begin
        failures++;
        $display("FAIL psz3_pkt%0d: got %0d, required %0d", i, cap_b[i], exp_p[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_slow_peer();
    test_reset_mid();
    test_push_pop();
    test_psz3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pakout_ser.md
PAKOUT_SER -- requirements
Module: pakout_ser

Interface
REQ-001 Parameters: PSZ, default 4, packet width in bits; ASZ, default 6, address width; DSZ, default 4, data width; RSZ, default 4, redundancy width; FDEPTH, default 2, message FIFO depth (power of two, >=2).
REQ-002 Derived: MSZ=2*ASZ+DSZ+RSZ; TOT_PKS=ceil(MSZ/PSZ); defaults give MSZ=20, TOT_PKS=5.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all logic on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 i0_src  in  ASZ  message source address.
REQ-007 i0_dst  in  ASZ  message destination address.
REQ-008 i0_dat  in  DSZ  message data.
REQ-009 i0_red  in  RSZ  message redundancy; passed through unchecked.
REQ-010 i0_req  in  1  four-phase message request.
REQ-011 i0_ack  out  1  four-phase message acknowledge.
REQ-012 o0_pak  out  PSZ  current packet payload.
REQ-013 o0_req  out  1  four-phase packet request.
REQ-014 o0_ack  in  1  four-phase packet acknowledge; may be asynchronous to clk.

Function
REQ-015 Message word: W={src,dst,dat,red}, src in the MSBs; packet k (k=0..TOT_PKS-1) = W[MSZ-1-k*PSZ -: PSZ]; bits below W[0] in the last packet are zero.
REQ-016 o0_ack passes a two-flop synchronizer before use; o0_ack_s denotes the synchronized value.
REQ-017 Input side, cycle-level: when i0_req=1, i0_ack=0 and the FIFO is not full, the FIFO captures {src,dst,dat,red} and i0_ack goes 1 on the next edge.
REQ-018 i0_ack stays 1 while i0_req=1 and clears on the first edge after i0_req is seen 0; no new message is accepted while i0_ack=1.
REQ-019 FIFO full: i0_req is held off (i0_ack stays 0) until an entry is freed; no message is lost or overwritten.
REQ-020 Output FSM states: IDLE, LOAD, REQ_HI, REQ_LO.
REQ-021 IDLE -> LOAD when the FIFO is not empty; the head entry is copied to a shift register and the packet counter is cleared.
REQ-022 LOAD drives o0_pak with packet[cnt] and goes to REQ_HI on the next edge, where o0_req is 1.
REQ-023 REQ_HI -> REQ_LO when o0_ack_s=1; o0_req clears on that edge.
REQ-024 REQ_LO waits for o0_ack_s=0, then: if cnt<TOT_PKS-1, increment cnt and go to LOAD; else pop the FIFO and go to IDLE.
REQ-025 o0_pak is stable from LOAD through the REQ_LO exit; it never changes while o0_req=1.
REQ-026 The counter is $clog2(TOT_PKS) bits wide and wraps to 0 only through IDLE->LOAD.
REQ-027 Push and pop in the same cycle are both honoured; occupancy is unchanged.
REQ-028 Messages leave in arrival order; back-to-back messages are separated by at least the one IDLE cycle.

Reset
REQ-029 On reset: i0_ack=0, o0_req=0, o0_pak=0, FSM=IDLE, cnt=0, FIFO empty, synchronizer flops=0.
REQ-030 Reset mid-packet drops o0_req on the same edge and discards all buffered messages; the peer must restart its own handshake.

Structure
REQ-031 MSZ, TOT_PKS and the FSM state encodings belong in the shared ns header package next to the existing packet-size macros.
REQ-032 A single sub-module, msg_fifo (parameters FDEPTH and width MSZ; push/pop/full/empty), holds the message buffer.

Verification
REQ-033 One message (src=3, dst=1, dat=5, red=15) with an immediate-ack peer: W=0x0C15F, packets 0x0, 0xC, 0x1, 0x5, 0xF in order, then IDLE.
REQ-034 Three messages pushed while o0_ack is held 0: the first two are acked, the third's i0_ack stays 0 until the first message has fully drained; output order is 1, 2, 3.
REQ-035 o0_ack delayed 7 cycles per phase: o0_pak is stable throughout every o0_req=1 window; per-packet period >= 2+7+2+7 cycles.
REQ-036 Reset asserted during packet 2 of 5: the next cycle shows o0_req=0, i0_ack=0, FIFO empty; a new message afterwards starts at packet 0.
REQ-037 Pop of message 1 and push of message 2 in the same cycle: occupancy stays 1 and message 2 is sent intact.
REQ-038 PSZ=3 build (MSZ=20, TOT_PKS=7): the last packet is W[1:0] followed by one zero bit.
